// File: rtl/replace_num_parser.sv
`default_nettype none
// ============================================================================
// Module   : replace_num_parser
// Brief    : Parses ID/payload/checksum replace-number messages from a UART
//            byte stream and issues one-cycle memory writes.
// Revision : 1.0
// ============================================================================
module replace_num_parser #(
    parameter int          ADDR_WIDTH     = 8,
    parameter int          DATA_WIDTH     = 8,
    parameter logic [7:0]  MSG_ID         = 8'h02,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [7:0]                       rx_data,
    input  logic                             rx_valid,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] wr_packet,
    output logic                             wr_en,
    output logic                             err,
    output logic                             busy
);

    localparam int PKT_W         = ADDR_WIDTH + DATA_WIDTH;
    localparam int PAYLOAD_BYTES = (PKT_W + 7) / 8;
    localparam int SHIFT_W       = PAYLOAD_BYTES * 8;
    localparam int BCW           = $clog2(PAYLOAD_BYTES + 1);
    localparam int TW            = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CHECK   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BCW-1:0]     cnt_q, cnt_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [7:0]         csum_q, csum_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [PKT_W-1:0]   pkt_q, pkt_d;
    logic               wr_en_q, wr_en_d;
    logic               err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            csum_q  <= '0;
            tmo_q   <= '0;
            pkt_q   <= '0;
            wr_en_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            csum_q  <= csum_d;
            tmo_q   <= tmo_d;
            pkt_q   <= pkt_d;
            wr_en_q <= wr_en_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        csum_d  = csum_q;
        tmo_d   = tmo_q;
        pkt_d   = pkt_q;
        wr_en_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (rx_valid && (rx_data == MSG_ID)) begin
                    csum_d  = MSG_ID;
                    cnt_d   = '0;
                    state_d = S_PAYLOAD;
                end
            end

            S_PAYLOAD: begin
                if (rx_valid) begin
                    // Big-endian: earliest byte ends up most significant.
                    shift_d = (shift_q << 8) | SHIFT_W'(rx_data);
                    csum_d  = csum_q ^ rx_data;
                    cnt_d   = cnt_q + BCW'(1);
                    tmo_d   = '0;
                    if (cnt_q == BCW'(PAYLOAD_BYTES - 1)) begin
                        state_d = S_CHECK;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            S_CHECK: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        wr_en_d = 1'b1;
                        pkt_d   = shift_q[PKT_W-1:0];
                    end else begin
                        err_d = 1'b1;
                    end
                    tmo_d   = '0;
                    state_d = S_IDLE;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                tmo_d   = '0;
            end
        endcase
    end

    assign wr_packet = pkt_q;
    assign wr_en     = wr_en_q;
    assign err       = err_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire
